// File: rtl/fifo_thresh_if.sv
// Handshake and status bundle for fifo_thresh.
// The master side drives write/read/flush requests; the slave side is the FIFO.
interface fifo_thresh_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush_i;
  logic             wr_en_i;
  logic [WIDTH-1:0] write_data_i;
  logic             rd_en_i;
  logic [WIDTH-1:0] read_data_o;
  logic             rd_valid_o;
  logic             full_o;
  logic             empty_o;
  logic             almost_full_o;
  logic             almost_empty_o;
  logic [CNT_W-1:0] count_o;
  logic             overflow_o;
  logic             underflow_o;

  modport master (
    output flush_i, wr_en_i, write_data_i, rd_en_i,
    input  read_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
           almost_empty_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, wr_en_i, write_data_i, rd_en_i,
    output read_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
           almost_empty_o, count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_thresh.sv
// Synchronous FIFO with occupancy thresholds, sticky error flags and a
// selectable read mode (registered read or first-word-fall-through).
// Every one of the DEPTH entries is usable; occupancy is tracked by an
// explicit counter so DEPTH need not be a power of two.
module fifo_thresh #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  fifo_thresh_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [31:0]      AF_U     = 32'(AF_LEVEL);
  localparam logic [31:0]      AE_U     = 32'(AE_LEVEL);

  // Pointer advance with an explicit wrap at DEPTH-1, so non power-of-two
  // depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             unf_q;
  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;

  // Flags come straight from the registered count; acceptance uses the
  // pre-edge flags, so a full FIFO refuses a write even when a read pops.
  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en_i && !full;
  assign rd_acc = bus.rd_en_i && !empty;

  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.almost_full_o  = (32'(count_q) >= AF_U);
  assign bus.almost_empty_o = (32'(count_q) <= AE_U);
  assign bus.count_o        = count_q;
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = unf_q;

  // Storage array: written on accepted writes only, never reset or cleared.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.flush_i && wr_acc) begin
      mem[wr_ptr_q] <= bus.write_data_i;
    end
  end

  // Pointers and occupancy; flush empties the queue and wins over requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (rd_acc) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (wr_acc && !rd_acc) begin
        count_q <= count_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Sticky error flags: held until flush or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.flush_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.wr_en_i && full) begin
        ovf_q <= 1'b1;
      end
      if (bus.rd_en_i && empty) begin
        unf_q <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; an empty queue presents zero so the
      // output is defined during and right after reset.
      assign bus.read_data_o = empty ? '0 : mem[rd_ptr_q];
      assign bus.rd_valid_o  = !empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rd_data_p1;
      logic             vld_p1;

      // ---- stage p0 -> p1: registered read, data held on refused reads ----
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else if (bus.flush_i) begin
          vld_p1     <= 1'b0;
        end else begin
          vld_p1 <= rd_acc;
          if (rd_acc) begin
            rd_data_p1 <= mem[rd_ptr_q];
          end
        end
      end

      assign bus.read_data_o = rd_data_p1;
      assign bus.rd_valid_o  = vld_p1;
    end
  endgenerate
endmodule

// File: tb/tb_fifo_thresh.sv
// Bench for fifo_thresh: two instances (registered read and FWFT), depth 5,
// fed identical stimulus and compared against a queue-based reference.
module tb_fifo_thresh;
  localparam int DEPTH = 5;
  localparam int WIDTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fifo_thresh_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) b_reg ();
  fifo_thresh_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) b_ft ();

  fifo_thresh #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .bus(b_reg)
  );
  fifo_thresh #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1)) u_ft (
    .clk(clk), .rst_n(rst_n), .bus(b_ft)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_unf;
  bit         m_vld;
  logic [7:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_vld   = 1'b0;
    m_rdata = 8'h00;
  endtask

  task automatic model_step(input bit fl, input bit wr, input logic [7:0] wd, input bit rd);
    bit was_full;
    bit was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_vld = 1'b0;
    end else begin
      if (wr && was_full) m_ovf = 1'b1;
      if (rd && was_empty) m_unf = 1'b1;
      m_vld = 1'b0;
      if (rd && !was_empty) begin
        m_rdata = q.pop_front();
        m_vld   = 1'b1;
      end
      if (wr && !was_full) q.push_back(wd);
    end
  endtask

  task automatic drive(input bit fl, input bit wr, input logic [7:0] wd, input bit rd);
    b_reg.flush_i      = fl;
    b_reg.wr_en_i      = wr;
    b_reg.write_data_i = wd;
    b_reg.rd_en_i      = rd;
    b_ft.flush_i       = fl;
    b_ft.wr_en_i       = wr;
    b_ft.write_data_i  = wd;
    b_ft.rd_en_i       = rd;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count",     32'(b_reg.count_o), 32'(n));
    chk("ft_count",  32'(b_ft.count_o), 32'(n));
    chk("full",      32'(b_reg.full_o), 32'(n == DEPTH));
    chk("ft_full",   32'(b_ft.full_o), 32'(n == DEPTH));
    chk("empty",     32'(b_reg.empty_o), 32'(n == 0));
    chk("ft_empty",  32'(b_ft.empty_o), 32'(n == 0));
    chk("afull",     32'(b_reg.almost_full_o), 32'(n >= AF));
    chk("aempty",    32'(b_reg.almost_empty_o), 32'(n <= AE));
    chk("ovf",       32'(b_reg.overflow_o), 32'(m_ovf));
    chk("unf",       32'(b_reg.underflow_o), 32'(m_unf));
    chk("ft_ovf",    32'(b_ft.overflow_o), 32'(m_ovf));
    chk("ft_unf",    32'(b_ft.underflow_o), 32'(m_unf));
    chk("rd_valid",  32'(b_reg.rd_valid_o), 32'(m_vld));
    chk("rd_data",   32'(b_reg.read_data_o), 32'(m_rdata));
    chk("ft_valid",  32'(b_ft.rd_valid_o), 32'(n > 0));
    if (n > 0) chk("ft_data", 32'(b_ft.read_data_o), 32'(q[0]));
  endtask

  task automatic cycle(input bit fl, input bit wr, input logic [7:0] wd, input bit rd);
    drive(fl, wr, wd, rd);
    @(posedge clk);
    model_step(fl, wr, wd, rd);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int writes;
    int pw;
    int pr;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    model_reset();

    // Reset state, observed before any clock edge
    #1 rst_n = 1'b0;
    #2 check_all();
    chk("rst_data", 32'(b_reg.read_data_o), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full, then one dropped write
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'(8'h11 + i), 1'b0);
    chk("full_after5", 32'(b_reg.full_o), 32'h1);
    chk("count5", 32'(b_reg.count_o), 32'd5);
    cycle(1'b0, 1'b1, 8'h16, 1'b0);
    chk("ovf_set", 32'(b_reg.overflow_o), 32'h1);
    chk("count_still5", 32'(b_reg.count_o), 32'd5);

    // Drain in order, then one refused read
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      chk("drain_data", 32'(b_reg.read_data_o), 32'(8'h11 + i));
      chk("drain_vld", 32'(b_reg.rd_valid_o), 32'h1);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("unf_set", 32'(b_reg.underflow_o), 32'h1);
    chk("hold_data", 32'(b_reg.read_data_o), 32'h15);
    chk("no_vld", 32'(b_reg.rd_valid_o), 32'h0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);

    // Twelve writes interleaved with reads across pointer wraps
    writes = 0;
    while (writes < 12) begin
      cycle(1'b0, 1'b1, 8'(8'h20 + writes), q.size() >= 2);
      writes++;
    end
    while (q.size() > 0) cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Simultaneous read/write at count 3, then at full
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8'(8'h50 + i), 1'b1);
      chk("rw_count3", 32'(b_reg.count_o), 32'd3);
    end
    cycle(1'b0, 1'b1, 8'h60, 1'b0);
    cycle(1'b0, 1'b1, 8'h61, 1'b0);
    cycle(1'b0, 1'b1, 8'h62, 1'b1);
    chk("full_rw_count4", 32'(b_reg.count_o), 32'd4);
    chk("full_rw_ovf", 32'(b_reg.overflow_o), 32'h1);

    // Flush with count 4 and overflow set
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    chk("flush_count", 32'(b_reg.count_o), 32'd0);
    chk("flush_empty", 32'(b_reg.empty_o), 32'h1);
    chk("flush_ovf", 32'(b_reg.overflow_o), 32'h0);

    // First-word-fall-through visibility and pop
    cycle(1'b0, 1'b1, 8'hA5, 1'b0);
    chk("ft_head", 32'(b_ft.read_data_o), 32'hA5);
    chk("ft_head_vld", 32'(b_ft.rd_valid_o), 32'h1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ft_pop_vld", 32'(b_ft.rd_valid_o), 32'h0);

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    chk("arst_count", 32'(b_reg.count_o), 32'd0);
    chk("arst_data", 32'(b_reg.read_data_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with shifting read/write bias
    for (int i = 0; i < 400; i++) begin
      pw = ((i / 100) % 2 == 0) ? 70 : 35;
      pr = ((i / 100) % 2 == 0) ? 35 : 70;
      cycle($urandom_range(0, 59) == 0,
            $urandom_range(0, 99) < pw,
            8'($urandom),
            $urandom_range(0, 99) < pr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
